// File: rtl/crc_32_frame_feeder.sv
// Store-and-forward frame buffer that replays whole frames to a
// byte-parallel CRC-32 engine as load / data burst / finish.
module crc_32_frame_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             load,
  output logic [7:0]       crc_in,
  output logic             crc_en,
  output logic             d_finish,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DATA,
    FINISH
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;
  logic [AW:0]     fs_q, fs_d;
  logic            drop_q, drop_d;
  logic            ready_q, ready_d;
  logic            push, dpush, pop, pop_last, flush;
  logic [8:0]      rd;

  logic            load_q, load_d;
  logic [7:0]      crc_in_q, crc_in_d;
  logic            crc_en_q, crc_en_d;
  logic            fin_q, fin_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign push     = s_valid && ready_q && !drop_q;
  assign dpush    = s_valid && ready_q && drop_q;
  assign pop      = (state_q == DATA);
  assign rd       = mem_q[rptr_q];
  assign pop_last = pop && rd[8];
  assign flush    = (state_q == IDLE) && (count_q == FULL) && (fs_q == '0);

  // Occupancy, complete-frame count and drop-mode next state
  always_comb begin
    count_d = count_q;
    fs_d    = fs_q;
    drop_d  = drop_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    if ((push && s_last) && !pop_last) fs_d = fs_q + 1'b1;
    if (pop_last && !(push && s_last)) fs_d = fs_q - 1'b1;
    if (dpush && s_last) drop_d = 1'b0;
    if (flush) begin
      count_d = '0;
      drop_d  = 1'b1;
    end
    ready_d = drop_d || (count_d != FULL);
  end

  // FIFO pointers, counters, drop mode and registered s_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fs_q    <= '0;
      drop_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      fs_q    <= fs_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Byte storage, tagged with the end-of-frame flag
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {s_last, s_data};
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start a burst once a complete frame is buffered
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fs_q != '0) state_d = LOAD;
      LOAD:    state_d = DATA;
      DATA:    if (pop_last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from state and registered one cycle later
  always_comb begin
    load_d   = (state_q == LOAD);
    crc_en_d = pop;
    fin_d    = (state_q == FINISH);
    busy_d   = (state_q != IDLE);
    err_d    = flush;
    cnt_d    = cnt_q;
    crc_in_d = crc_in_q;
    if (state_q == LOAD) crc_in_d = 8'h00;
    if (pop) crc_in_d = rd[7:0];
    if (state_q == FINISH) cnt_d = cnt_q + 1'b1;
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q   <= 1'b0;
      crc_in_q <= '0;
      crc_en_q <= 1'b0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      load_q   <= load_d;
      crc_in_q <= crc_in_d;
      crc_en_q <= crc_en_d;
      fin_q    <= fin_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_ready   = ready_q;
  assign load      = load_q;
  assign crc_in    = crc_in_q;
  assign crc_en    = crc_en_q;
  assign d_finish  = fin_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;

endmodule
